// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction master: FSM state codes,
// quarter-phase codes within one SCL bit, and R/W bit values.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StStart  = 4'd1,
    StAddr   = 4'd2,
    StAckA   = 4'd3,
    StWaitWr = 4'd4,
    StWrite  = 4'd5,
    StAckW   = 4'd6,
    StRead   = 4'd7,
    StMack   = 4'd8,
    StStop   = 4'd9,
    StGap    = 4'd10
  } i2c_state_e;

  // Quarter phases of one SCL bit period
  localparam logic [1:0] Q0 = 2'd0;  // SCL low, SDA updated
  localparam logic [1:0] Q1 = 2'd1;  // SCL released
  localparam logic [1:0] Q2 = 2'd2;  // SDA sampled
  localparam logic [1:0] Q3 = 2'd3;  // SCL low

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_clk_div.sv
// Quarter-period tick generator: counts 0..CLK_DIV-1 and pulses o_tick on the
// last count. While i_freeze is high the count holds and no tick is emitted.
module i2c_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_freeze,
  output logic o_tick
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] r_cnt;
  logic            w_tick;

  assign w_tick = !i_freeze && (r_cnt == CntLast);
  assign o_tick = w_tick;

  // Divider counter; wraps to zero on the tick so a frozen restart begins a fresh quarter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else if (!i_freeze) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_master_xfer.sv
// I2C transaction master: START, {addr,rw}, ACK check, 0..2^LEN_W-1 data
// bytes (write or read), STOP, then a bus-free gap before the next command.
// Optional feature macro: I2C_CLK_STRETCH_EN (target clock stretching via i_scl_in).
module i2c_master_xfer
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned LEN_W    = 4,
  parameter int unsigned IDLE_GAP = 4
) (
  input  logic             i_i2c_clk,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [6:0]       i_cmd_addr,
  input  logic             i_cmd_rw,
  input  logic [LEN_W-1:0] i_cmd_len,
  input  logic [7:0]       i_wr_data,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  output logic [7:0]       o_rd_data,
  output logic             o_rd_valid,
  output logic             o_done,
  output logic             o_err_nack,
  output logic             o_busy,
  output logic             o_scl,
  input  logic             i_scl_in,
  inout  wire              io_sda_line,
  output logic [3:0]       o_state_out
);

  localparam int unsigned GapW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'(IDLE_GAP - 1);

  i2c_state_e       r_state, w_state_d;
  logic [1:0]       r_q;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic [6:0]       r_addr;
  logic             r_rw;
  logic [LEN_W-1:0] r_rem;
  logic             r_ack;
  logic [GapW-1:0]  r_gap;
  logic             r_busy, r_err, r_wr_ready, r_rd_valid, r_done;
  logic [7:0]       r_rd_data;

  logic w_tick, w_freeze, w_stretch, w_bit_end, w_sample;
  logic w_scl, w_sda_low, w_sda_in, w_scl_pat;

`ifdef I2C_CLK_STRETCH_EN
  // Hold the released-SCL quarter while a target keeps the line low
  assign w_stretch = (r_q == Q1) && !i_scl_in &&
                     (r_state inside {StAddr, StAckA, StWrite, StAckW, StRead, StMack, StStop});
`else
  logic w_unused_scl_in;
  assign w_unused_scl_in = i_scl_in;
  assign w_stretch       = 1'b0;
`endif

  assign w_freeze  = (r_state == StIdle) || (r_state == StWaitWr) || w_stretch;
  assign w_bit_end = w_tick && (r_q == Q3);
  assign w_sample  = w_tick && (r_q == Q2);
  assign w_sda_in  = io_sda_line;
  assign w_scl_pat = (r_q == Q1) || (r_q == Q2);

  i2c_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .i_clk    (i_i2c_clk),
    .i_rst    (i_reset),
    .i_freeze (w_freeze),
    .o_tick   (w_tick)
  );

  // FSM state register
  always_ff @(posedge i_i2c_clk or posedge i_reset) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_d;
  end

  // FSM next-state logic; bit-level states advance at the end of quarter 3
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:   if (i_cmd_valid) w_state_d = StStart;
      StStart:  if (w_bit_end) w_state_d = StAddr;
      StAddr:   if (w_bit_end && (r_bit == 3'd7)) w_state_d = StAckA;
      StAckA: begin
        if (w_bit_end) begin
          if (r_ack || (r_rem == '0)) w_state_d = StStop;
          else if (r_rw == I2C_READ)  w_state_d = StRead;
          else                        w_state_d = StWaitWr;
        end
      end
      StWaitWr: if (i_wr_valid) w_state_d = StWrite;
      StWrite:  if (w_bit_end && (r_bit == 3'd7)) w_state_d = StAckW;
      StAckW: begin
        if (w_bit_end) begin
          if (r_ack || (r_rem == LEN_W'(1))) w_state_d = StStop;
          else                               w_state_d = StWaitWr;
        end
      end
      StRead:   if (w_bit_end && (r_bit == 3'd7)) w_state_d = StMack;
      StMack: begin
        if (w_bit_end) w_state_d = (r_rem == LEN_W'(1)) ? StStop : StRead;
      end
      StStop:   if (w_bit_end) w_state_d = StGap;
      StGap:    if (w_tick && (r_gap == GapLast)) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // FSM outputs: bus line levels decoded from state, quarter and shift data
  always_comb begin
    w_scl     = 1'b1;
    w_sda_low = 1'b0;
    case (r_state)
      StStart: begin
        w_scl     = (r_q != Q3);
        w_sda_low = (r_q != Q0);
      end
      StAddr, StWrite: begin
        w_scl     = w_scl_pat;
        w_sda_low = !r_shift[7];
      end
      StAckA, StAckW, StRead: w_scl = w_scl_pat;
      StWaitWr: w_scl = 1'b0;
      StMack: begin
        w_scl     = w_scl_pat;
        w_sda_low = (r_rem > LEN_W'(1));
      end
      StStop: begin
        w_scl     = (r_q != Q0);
        w_sda_low = (r_q == Q0) || (r_q == Q1);
      end
      default: ;
    endcase
  end

  assign o_scl       = w_scl;
  assign io_sda_line = w_sda_low ? 1'b0 : 1'bz;
  assign o_cmd_ready = (r_state == StIdle);
  assign o_state_out = r_state;
  assign o_busy      = r_busy;
  assign o_err_nack  = r_err;
  assign o_wr_ready  = r_wr_ready;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_data   = r_rd_data;
  assign o_done      = r_done;

  // Datapath: quarter phase, shift register, byte counter, status and pulses
  always_ff @(posedge i_i2c_clk or posedge i_reset) begin
    if (i_reset) begin
      r_q        <= Q0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_addr     <= '0;
      r_rw       <= I2C_WRITE;
      r_rem      <= '0;
      r_ack      <= 1'b1;
      r_gap      <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_wr_ready <= 1'b0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_wr_ready <= 1'b0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      if (r_state == StIdle) r_q <= Q0;
      else if (w_tick)       r_q <= r_q + 2'd1;
      case (r_state)
        StIdle: begin
          if (i_cmd_valid) begin
            r_addr <= i_cmd_addr;
            r_rw   <= i_cmd_rw;
            r_rem  <= i_cmd_len;
            r_err  <= 1'b0;
            r_busy <= 1'b1;
          end
        end
        StStart: begin
          if (w_bit_end) begin
            r_shift <= {r_addr, r_rw};
            r_bit   <= '0;
          end
        end
        StAddr, StWrite: begin
          if (w_bit_end) begin
            r_shift <= {r_shift[6:0], 1'b0};
            r_bit   <= r_bit + 3'd1;
          end
        end
        StAckA: begin
          if (w_sample) r_ack <= w_sda_in;
          if (w_bit_end) begin
            r_bit <= '0;
            if (r_ack) r_err <= 1'b1;
          end
        end
        StWaitWr: begin
          if (i_wr_valid) begin
            r_wr_ready <= 1'b1;
            r_shift    <= i_wr_data;
            r_bit      <= '0;
          end
        end
        StAckW: begin
          if (w_sample) r_ack <= w_sda_in;
          if (w_bit_end) begin
            if (r_ack) r_err <= 1'b1;
            else       r_rem <= r_rem - LEN_W'(1);
          end
        end
        StRead: begin
          if (w_sample) r_shift <= {r_shift[6:0], w_sda_in};
          if (w_bit_end) begin
            r_bit <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
              r_rd_data  <= r_shift;
              r_rd_valid <= 1'b1;
            end
          end
        end
        StMack: begin
          if (w_bit_end) begin
            r_rem <= r_rem - LEN_W'(1);
            r_bit <= '0;
          end
        end
        StStop: if (w_bit_end) r_gap <= '0;
        StGap: begin
          if (w_tick) begin
            if (r_gap == GapLast) begin
              r_done <= 1'b1;
              r_busy <= 1'b0;
            end else begin
              r_gap <= r_gap + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/i2c_master_xfer.md
Name: i2c_master_xfer

Overview:
- Parametrised successor to the fixed single-byte I2C write master.
- Runs complete I2C transactions from a command interface:
  - 7-bit target address taken from a port.
  - Read or write direction.
  - 0..2^LEN_W-1 data bytes.
  - Programmable SCL rate.
  - ACK checking with NACK abort.
- Sits between a CPU/register-bank command source and the open-drain I2C pads.

Parameters:
- CLK_DIV, 4: i2c_clk cycles per SCL quarter-period; legal range ≥2.
- LEN_W, 4: width of the byte-count field.
- IDLE_GAP, 4: quarter-periods of bus-free time held after STOP before a new START.

Ports:
- i2c_clk  in  1  block clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  start request.
- cmd_ready  out  1  high in IDLE only.
- cmd_addr  in  7  target address.
- cmd_rw  in  1  0 = write, 1 = read.
- cmd_len  in  LEN_W  byte count; 0 = address-only probe.
- wr_data  in  8  next write byte.
- wr_valid  in  1  wr_data valid.
- wr_ready  out  1  one-cycle pulse when the byte is accepted.
- rd_data  out  8  received byte.
- rd_valid  out  1  one-cycle pulse; rd_data stable until the next pulse.
- done  out  1  one-cycle pulse after STOP completes.
- err_nack  out  1  sticky; cleared on the next accepted command.
- busy  out  1  high from command accept to done.
- scl  out  1  SCL drive; 1 = released.
- scl_in  in  1  sampled SCL pad (used only with the optional feature).
- sda_line  inout  1  open drain: driven 0 or Z, never driven 1.
- state_out  out  4  current FSM state, for debug.

Behaviour:
- Reset values (asynchronous, active-high):
  - state = IDLE, scl = 1, SDA released.
  - cmd_ready = 1, busy = 0, wr_ready = 0, rd_valid = 0, done = 0, err_nack = 0, rd_data = 0.
  - Counters cleared.
- Reset asserted mid-transaction releases both lines immediately. No STOP is generated.
- Timing base: divider counts 0..CLK_DIV-1 and emits a tick; each tick advances a 2-bit quarter counter q.
- Per-bit sequence:
  - q0: SCL low; SDA updated.
  - q1: SCL released (high).
  - q2: SDA sampled.
  - q3: SCL low.
- One SCL period = 4*CLK_DIV cycles.
- State encoding: IDLE = 0, START = 1, ADDR = 2, ACK_A = 3, WAIT_WR = 4, WRITE = 5, ACK_W = 6, READ = 7, MACK = 8, STOP = 9, GAP = 10.
- Transitions:
  - IDLE: when cmd_valid is high, latch addr/rw/len, clear err_nack, set busy, go to START.
  - START: SDA falls while SCL is high (q1), SCL falls (q3), go to ADDR.
  - ADDR: shift out {addr, rw}, MSB first; 8 bits, then ACK_A.
  - ACK_A: release SDA, sample at q2.
    - NACK (1): set err_nack, go to STOP.
    - len = 0: go to STOP.
    - rw = 0: go to WAIT_WR.
    - rw = 1: go to READ.
  - WAIT_WR: SCL held low; divider frozen. When wr_valid is high, pulse wr_ready and load the shift register, then go to WRITE.
  - WRITE: 8 bits MSB first, then ACK_W.
  - ACK_W: NACK sets err_nack and goes to STOP. Otherwise decrement remaining; if remaining = 0 go to STOP, else go to WAIT_WR.
  - READ: SDA released; shift in at q2 for 8 bits. At the end of the 8th bit, update rd_data and pulse rd_valid, then go to MACK.
  - MACK: drive 0 (ACK) if remaining > 1; release (NACK) on the last byte. Decrement remaining, then go to READ or STOP.
  - STOP: SDA low at q0, SCL high at q1, SDA released at q2 (STOP condition), then go to GAP.
  - GAP: wait IDLE_GAP ticks, pulse done, clear busy, go to IDLE.
- cmd_valid while busy is ignored (cmd_ready = 0).
- cmd_len = 2^LEN_W-1 must complete with no counter wrap.
- rd_valid has no backpressure; the consumer must take each byte within 9 SCL periods.

Optional Feature:
- Macro: I2C_CLK_STRETCH_EN.
- Defined: after SCL is released (q1), the FSM holds q1 and freezes the divider until scl_in = 1. A target holding SCL low stretches the bit by exactly the hold time.
- Undefined: scl_in is ignored; timing is purely divider-based.

Decomposition:
- Package i2c_pkg holds:
  - the state enum/localparams;
  - quarter-phase codes;
  - R/W bit constants (I2C_WRITE = 0, I2C_READ = 1).
- Sub-module i2c_clk_div: counter producing the tick, with a freeze input; parametrised by CLK_DIV.
- The FSM/shift logic stays in i2c_master_xfer.

Test Plan:
- Write, 2 bytes:
  - Stimulus: addr 7'h69, len 2, bytes 8'hAA then 8'h55; behavioural ACKing target.
  - Required: bus shows START, 0xD2, ACK, 0xAA, ACK, 0x55, ACK, STOP; 2 wr_ready pulses; done pulses once; err_nack = 0.
- Read, 3 bytes:
  - Stimulus: addr 7'h50; target returns 0x12, 0x34, 0x56.
  - Required: 3 rd_valid pulses with those values; master ACK, ACK, NACK; STOP.
- Address NACK:
  - Stimulus: target absent (SDA pulled high).
  - Required: err_nack = 1; STOP follows the 9th clock; done pulses; no wr_ready pulse.
- Write stall and probe:
  - Stimulus: wr_valid withheld 50 cycles in WAIT_WR; then a second command with len 0.
  - Required: SCL stays low through the stall; the probe sends address + ACK + STOP only.
- Timing and reset:
  - Stimulus: CLK_DIV = 8; assert reset mid-READ.
  - Required: SCL period = 32 cycles; on reset, scl = 1 and SDA = Z within the same cycle; all outputs at reset values.
- Clock stretch (with I2C_CLK_STRETCH_EN):
  - Stimulus: target holds scl_in low 20 cycles on bit 3.
  - Required: that bit's high phase is delayed by 20 cycles; data is unchanged.
